// File: rtl/one_hot_iterator.sv
// Serialises a captured request vector into one-hot words with index, under valid/ready flow control.
// Optional ONE_HOT_ITERATOR_COUNT_EN drives `remaining` with the pending-bit popcount.
module one_hot_iterator #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned LSB_FIRST = 1,
  localparam int unsigned IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  input  logic             flush,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [IDX_W-1:0] out_idx,
  output logic             last,
  output logic             done,
  output logic [IDX_W:0]   remaining
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] pending, pending_next;
  logic             done_q, done_next;
  logic [IDX_W-1:0] sel_idx, k;
  logic             accept;

  // The state is not stored separately: RUN is exactly "pending is non-empty".
  assign state     = (pending != '0) ? RUN : IDLE;
  assign busy      = (state == RUN);
  assign out_valid = busy;
  assign accept    = out_valid & out_ready;
  assign done      = done_q;

  // Scan so that the preferred end of the vector is written last and wins.
  always_comb begin
    sel_idx = '0;
    k       = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (LSB_FIRST != 0) k = IDX_W'(WIDTH - 1 - i);
      else                k = IDX_W'(i);
      if (pending[k]) sel_idx = k;
    end
  end

  assign out     = busy ? (WIDTH'(1) << sel_idx) : '0;
  assign out_idx = busy ? sel_idx : '0;
  assign last    = busy && ((pending & (pending - WIDTH'(1))) == '0);

  always_comb begin
    pending_next = pending;
    done_next    = 1'b0;
    if (flush) begin
      pending_next = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load) begin
            pending_next = in;
            done_next    = (in == '0);
          end
        end
        RUN: begin
          if (accept) begin
            pending_next = pending & ~out;
            done_next    = last;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pending <= '0;
      done_q  <= 1'b0;
    end else begin
      pending <= pending_next;
      done_q  <= done_next;
    end
  end

`ifdef ONE_HOT_ITERATOR_COUNT_EN
  logic [IDX_W:0] cnt;

  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt = cnt + (IDX_W+1)'(pending[IDX_W'(i)]);
    end
  end

  assign remaining = cnt;
`else
  assign remaining = '0;
`endif

endmodule

// File: tb/tb_one_hot_iterator.sv
// Self-checking bench: an LSB-first and an MSB-first iterator share stimulus and are
// compared each cycle against queue-based reference models of the pending bit order.
module tb_one_hot_iterator;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] vec = '0;
  logic         flush = 1'b0;
  logic         out_ready = 1'b0;

  logic         busy_l, valid_l, last_l, done_l;
  logic [W-1:0] out_l;
  logic [2:0]   idx_l;
  logic [3:0]   rem_l;
  logic         busy_m, valid_m, last_m, done_m;
  logic [W-1:0] out_m;
  logic [2:0]   idx_m;
  logic [3:0]   rem_m;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference models: queue of pending bit indices in emission order, plus done flag.
  int q_l[$];
  int q_m[$];
  bit d_l, d_m;

  always #5 clk = ~clk;

  one_hot_iterator #(.WIDTH(W), .LSB_FIRST(1)) dut_lsb (
    .clk(clk), .nrst(nrst), .load(load), .in(vec), .flush(flush),
    .busy(busy_l), .out_valid(valid_l), .out_ready(out_ready), .out(out_l),
    .out_idx(idx_l), .last(last_l), .done(done_l), .remaining(rem_l)
  );

  one_hot_iterator #(.WIDTH(W), .LSB_FIRST(0)) dut_msb (
    .clk(clk), .nrst(nrst), .load(load), .in(vec), .flush(flush),
    .busy(busy_m), .out_valid(valid_m), .out_ready(out_ready), .out(out_m),
    .out_idx(idx_m), .last(last_m), .done(done_m), .remaining(rem_m)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_dut(input string name, input int qsize, input int head, input bit d,
                           input logic bsy, input logic vld, input logic [W-1:0] o,
                           input logic [2:0] ix, input logic lst, input logic dn,
                           input logic [3:0] rem);
    logic [W-1:0] exp_out;
    int exp_rem;
    exp_out = (qsize > 0) ? (W'(1) << head) : '0;
`ifdef ONE_HOT_ITERATOR_COUNT_EN
    exp_rem = qsize;
`else
    exp_rem = 0;
`endif
    check({name, ".busy"},      32'(bsy), 32'(qsize > 0));
    check({name, ".out_valid"}, 32'(vld), 32'(qsize > 0));
    check({name, ".out"},       32'(o),   32'(exp_out));
    check({name, ".out_idx"},   32'(ix),  (qsize > 0) ? 32'(head) : 32'd0);
    check({name, ".last"},      32'(lst), 32'(qsize == 1));
    check({name, ".done"},      32'(dn),  32'(d));
    check({name, ".remaining"}, 32'(rem), 32'(exp_rem));
  endtask

  task automatic check_all();
    check_dut("lsb", q_l.size(), (q_l.size() > 0) ? q_l[0] : 0, d_l,
              busy_l, valid_l, out_l, idx_l, last_l, done_l, rem_l);
    check_dut("msb", q_m.size(), (q_m.size() > 0) ? q_m[0] : 0, d_m,
              busy_m, valid_m, out_m, idx_m, last_m, done_m, rem_m);
  endtask

  task automatic model_clear();
    q_l.delete();
    q_m.delete();
    d_l = 0;
    d_m = 0;
  endtask

  // Advance both models by one clock using the currently driven inputs.
  task automatic model_step();
    if (flush) begin
      model_clear();
    end else begin
      if (q_l.size() == 0) begin
        d_l = 0;
        if (load) begin
          for (int i = 0; i < W; i++) if (vec[i]) q_l.push_back(i);
          d_l = (vec == '0);
        end
      end else begin
        d_l = 0;
        if (out_ready) begin
          void'(q_l.pop_front());
          d_l = (q_l.size() == 0);
        end
      end
      if (q_m.size() == 0) begin
        d_m = 0;
        if (load) begin
          for (int i = 0; i < W; i++) if (vec[i]) q_m.push_front(i);
          d_m = (vec == '0);
        end
      end else begin
        d_m = 0;
        if (out_ready) begin
          void'(q_m.pop_front());
          d_m = (q_m.size() == 0);
        end
      end
    end
  endtask

  // Called at a negedge: drive, clock once, check at the next negedge.
  task automatic cycle(input logic ld, input logic [W-1:0] v, input logic fl, input logic rdy);
    load = ld;
    vec = v;
    flush = fl;
    out_ready = rdy;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    model_clear();
    #2;
    check_all();
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    check_all();

    // LSB/MSB order with continuous ready, then toggling ready
    cycle(1'b1, 8'hA6, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b1, 8'hA6, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b0, (i % 2) == 0);

    // Empty load gives a lone done pulse
    cycle(1'b1, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Full load, accept three, ignored load during RUN, flush, no done
    cycle(1'b1, 8'hFF, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b1, 8'h01, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Full drain: remaining counts down to zero
    cycle(1'b1, 8'hFF, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Load coincident with the final accept is ignored
    cycle(1'b1, 8'h10, 1'b0, 1'b0);
    cycle(1'b1, 8'h3C, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] v;
      int sel;
      sel = $urandom_range(0, 9);
      v = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : W'($urandom);
      cycle($urandom_range(0, 3) == 0, v, $urandom_range(0, 29) == 0, $urandom_range(0, 2) != 0);
    end

    // Asynchronous reset mid-run
    cycle(1'b1, 8'hFF, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    #2;
    nrst = 1'b0;
    model_clear();
    #1;
    check_all();
    @(negedge clk);
    check_all();
    nrst = 1'b1;
    cycle(1'b1, 8'h81, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
